// File: rtl/nes_bus_pkg.sv
// Shared bus definitions for the NES-style system bus.
// Holds default register addresses and the sprite-DMA state encoding.
package nes_bus_pkg;

  localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_GET,
    ST_PUT
  } dma_state_e;

  function automatic logic is_dma_state(input dma_state_e s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA sequencer and CPU/DMA bus arbiter.
// Copies one 256-byte page to the OAM data port while the CPU is halted.
module oam_dma_ctrl
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_r_nw,
  input  logic [7:0]  bus_din,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_r_nw,
  output logic        cpu_rdy,
  output logic        dma_active
);

  dma_state_e state;
  dma_state_e state_nxt;

  logic       odd;
  logic [7:0] index;
  logic [7:0] page;
  logic [7:0] latch;
  logic       trig;

  assign trig = (cpu_addr == DMA_REG_ADDR) && !cpu_r_nw;

  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      odd   <= 1'b0;
      index <= 8'h00;
      page  <= 8'h00;
      latch <= 8'h00;
    end else begin
      state <= state_nxt;
      odd   <= ~odd;
      if (state == ST_IDLE && trig) begin
        page  <= cpu_dout;
        index <= 8'h00;
      end
      if (state == ST_GET)
        latch <= bus_din;
      // index wraps at FF; no carry into page
      if (state == ST_PUT)
        index <= index + 8'h01;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (trig)
          state_nxt = ST_HALT;
      end
      ST_HALT: begin
        // first CPU read is the halt cycle; realign so GET lands on odd==0
        if (cpu_r_nw)
          state_nxt = odd ? ST_GET : ST_ALIGN;
      end
      ST_ALIGN: state_nxt = ST_GET;
      ST_GET:   state_nxt = ST_PUT;
      ST_PUT: begin
        if (index == 8'hFF)
          state_nxt = ST_IDLE;
        else
          state_nxt = ST_GET;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_addr   = cpu_addr;
    bus_dout   = cpu_dout;
    bus_r_nw   = cpu_r_nw;
    cpu_rdy    = !is_dma_state(state);
    dma_active = is_dma_state(state);
    unique case (state)
      ST_GET: begin
        bus_addr = {page, index};
        bus_r_nw = 1'b1;
      end
      ST_PUT: begin
        bus_addr = OAM_DATA_ADDR;
        bus_r_nw = 1'b0;
        bus_dout = latch;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl against a transaction-level model.
// Expected bus traces are built from page contents and cycle parity.
module tb_oam_dma_ctrl;

  logic        clk_ph1 = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_r_nw = 1'b1;
  logic [7:0]  bus_din;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_r_nw;
  logic        cpu_rdy;
  logic        dma_active;

  logic [7:0]  mem [65536];
  logic [24:0] obs [$];
  logic [24:0] exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          stall;
  int          cyc;

  oam_dma_ctrl dut (
    .clk_ph1    (clk_ph1),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_r_nw   (cpu_r_nw),
    .bus_din    (bus_din),
    .bus_addr   (bus_addr),
    .bus_dout   (bus_dout),
    .bus_r_nw   (bus_r_nw),
    .cpu_rdy    (cpu_rdy),
    .dma_active (dma_active)
  );

  always #5 clk_ph1 = ~clk_ph1;

  assign bus_din = mem[bus_addr];

  always @(posedge clk_ph1)
    cyc <= rst ? 0 : cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic step();
    @(negedge clk_ph1);
    if (dma_active)
      obs.push_back({bus_addr, bus_r_nw,
                     bus_r_nw ? 8'h00 : bus_dout});
    if (!cpu_rdy)
      stall++;
    @(posedge clk_ph1);
    #1;
  endtask

  function automatic logic [15:0] rnd_addr();
    logic [15:0] a;
    a = 16'($urandom);
    if (a == 16'h4014)
      a = 16'h4015;
    return a;
  endfunction

  task automatic run_xfer(input logic [7:0] page,
                          input int k,
                          input bit want_align);
    logic [15:0] a;
    logic [7:0]  d;
    bit          align;
    int          n;
    obs.delete();
    exp_q.delete();
    stall = 0;
    if (((cyc + 1 + k) % 2 == 0) != want_align) begin
      cpu_addr = rnd_addr();
      cpu_r_nw = 1'b1;
      step();
    end
    cpu_addr = 16'h4014;
    cpu_dout = page;
    cpu_r_nw = 1'b0;
    step();
    for (int j = 0; j < k; j++) begin
      a = (j == 0) ? 16'h4014 : rnd_addr();
      d = (j == 0) ? ~page : 8'($urandom);
      cpu_addr = a;
      cpu_dout = d;
      cpu_r_nw = 1'b0;
      exp_q.push_back({a, 1'b0, d});
      step();
    end
    a = rnd_addr();
    cpu_addr = a;
    cpu_r_nw = 1'b1;
    align = (cyc % 2 == 0);
    exp_q.push_back({a, 1'b1, 8'h00});
    if (align)
      exp_q.push_back({a, 1'b1, 8'h00});
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({page, 8'(i), 1'b1, 8'h00});
      exp_q.push_back({16'h2004, 1'b0, mem[{page, 8'(i)}]});
    end
    n = 0;
    do begin
      step();
      n++;
    end while (!cpu_rdy && n < 700);
    if (n >= 700)
      check("timeout", 32'(n), 32'd0);
    check("stall_cycles", 32'(stall), 32'(k + 1 + int'(align) + 512));
    check("trace_len", 32'(obs.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      check($sformatf("trace[%0d]", i), 32'(obs[i]), 32'(exp_q[i]));
    check("resume_addr", 32'(bus_addr), 32'(a));
    check("resume_rnw", 32'(bus_r_nw), 32'd1);
  endtask

  initial begin
    int n;
    logic [7:0] pg;
    for (int i = 0; i < 65536; i++)
      mem[i] = 8'($urandom);

    rst = 1'b1;
    cpu_addr = 16'h1234;
    cpu_dout = 8'h5A;
    cpu_r_nw = 1'b0;
    repeat (3) @(posedge clk_ph1);
    #1;
    check("rst_cpu_rdy", 32'(cpu_rdy), 32'd1);
    check("rst_dma_active", 32'(dma_active), 32'd0);
    check("rst_bus_addr", 32'(bus_addr), 32'h1234);
    check("rst_bus_dout", 32'(bus_dout), 32'h5A);
    check("rst_bus_rnw", 32'(bus_r_nw), 32'd0);
    cpu_r_nw = 1'b1;
    rst = 1'b0;
    step();

    run_xfer(8'h02, 0, 1'b0);
    run_xfer(8'h02, 0, 1'b1);
    run_xfer(8'($urandom), 3, 1'($urandom));
    run_xfer(8'hFF, 0, 1'b0);
    run_xfer(8'hFF, 2, 1'b1);

    pg = 8'($urandom);
    cpu_addr = 16'h4014;
    cpu_dout = pg;
    cpu_r_nw = 1'b0;
    step();
    cpu_addr = rnd_addr();
    cpu_r_nw = 1'b1;
    n = 0;
    while (!(dma_active && bus_r_nw && bus_addr == {pg, 8'h40})
           && n < 700) begin
      step();
      n++;
    end
    check("reach_idx40", 32'(n < 700), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_cpu_rdy", 32'(cpu_rdy), 32'd1);
    check("midrst_dma_active", 32'(dma_active), 32'd0);
    check("midrst_bus_addr", 32'(bus_addr), 32'(cpu_addr));
    @(posedge clk_ph1);
    #1 rst = 1'b0;
    step();
    run_xfer(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

    for (int t = 0; t < 3; t++)
      run_xfer(8'($urandom), int'($urandom_range(0, 2)),
               1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
